tape_pulse_gen: RTL and testbench

TAPE_PULSE_GEN -- requirements
Module: tape_pulse_gen

---
 rtl/tape_pkg.sv | 15 +
 rtl/tape_period_counter.sv | 27 ++
 rtl/tape_pulse_gen.sv | 104 ++++++++++
 tb/tb_tape_pulse_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the tape playback path: pulse-generator states and
// the default timer width and starve limit used by the generator and sample assembler.
package tape_pkg;

  localparam int unsigned TICK_W_DEF       = 24;
  localparam int unsigned STARVE_LIMIT_DEF = 255;

  typedef enum logic [1:0] {
    PRIME     = 2'd0,
    WAIT_LOAD = 2'd1,
    LOW_PH    = 2'd2,
    HIGH_PH   = 2'd3
  } tape_state_e;

endpackage

// File: rtl/tape_period_counter.sv
// Loadable down-counter for the current pulse phase; flags the last tick of the phase.
module tape_period_counter #(
  parameter int unsigned TICK_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [TICK_W-1:0] load_val,
  input  logic              dec,
  output logic              one
);

  logic [TICK_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign one = (count == TICK_W'(1));

endmodule

// File: rtl/tape_pulse_gen.sv
// Tape-read waveform generator: turns per-period tick counts into a low/high pwm
// pulse whose falling edge requests the next period, with a sticky starve watchdog.
module tape_pulse_gen
  import tape_pkg::*;
#(
  parameter int unsigned TICK_W       = TICK_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              tick,
  input  logic [TICK_W-1:0] timer_val,
  input  logic              load_timer,
  output logic              pwm,
  output logic              starved
);

  localparam int unsigned WAIT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  tape_state_e       state;
  logic [TICK_W-1:0] half;
  logic [TICK_W-1:0] v;
  logic [TICK_W-1:0] load_val;
  logic [WAIT_W-1:0] wait_cnt;
  logic              step;
  logic              take_load;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_one;

  // The low phase gets the odd tick so LOW + HIGH always sums to v.
  always_comb begin
    v         = (timer_val == '0) ? TICK_W'(1) : timer_val;
    step      = tick & enable;
    take_load = (state == WAIT_LOAD) & load_timer;
    cnt_dec   = step & ((state == LOW_PH) | (state == HIGH_PH));
    cnt_load  = take_load | ((state == LOW_PH) & step & cnt_one & (half != '0));
    load_val  = take_load ? (v - (v >> 1)) : half;
  end

  tape_period_counter #(
    .TICK_W(TICK_W)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (load_val),
    .dec      (cnt_dec),
    .one      (cnt_one)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= PRIME;
      pwm      <= 1'b1;
      half     <= '0;
      wait_cnt <= '0;
      starved  <= 1'b0;
    end else begin
      case (state)
        PRIME: begin
          if (enable) begin
            pwm   <= 1'b0;
            state <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          pwm <= 1'b0;
          if (load_timer) begin
            half     <= v >> 1;
            wait_cnt <= '0;
            state    <= LOW_PH;
          end else begin
            if (int'(unsigned'(wait_cnt)) < int'(STARVE_LIMIT)) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            if (int'(unsigned'(wait_cnt)) + 1 >= int'(STARVE_LIMIT)) begin
              starved <= 1'b1;
            end
          end
        end
        LOW_PH: begin
          if (step && cnt_one) begin
            if (half != '0) begin
              pwm   <= 1'b1;
              state <= HIGH_PH;
            end else begin
              state <= WAIT_LOAD;
            end
          end
        end
        HIGH_PH: begin
          if (step && cnt_one) begin
            pwm   <= 1'b0;
            state <= WAIT_LOAD;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Directed bench for tape_pulse_gen: per-cycle expected pwm/starved pushed to a
// scoreboard when inputs are driven and compared after the following clock edge.
module tb_tape_pulse_gen;
  import tape_pkg::*;

  localparam int unsigned TW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          tick;
  logic          load_timer;
  logic [TW-1:0] timer_val;
  logic          pwm;
  logic          starved;

  always #5 clk = ~clk;

  tape_pulse_gen #(
    .TICK_W      (TW),
    .STARVE_LIMIT(255)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .tick      (tick),
    .timer_val (timer_val),
    .load_timer(load_timer),
    .pwm       (pwm),
    .starved   (starved)
  );

  typedef struct {
    string tag;
    logic  pwm;
    logic  starved;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic rn, input logic en, input logic tk,
                       input logic ld, input logic [TW-1:0] val);
    reset_n    = rn;
    enable     = en;
    tick       = tk;
    load_timer = ld;
    timer_val  = val;
  endtask

  task automatic cycle(input logic ep, input logic es, input string tag);
    exp_t e;
    e.tag     = tag;
    e.pwm     = ep;
    e.starved = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (pwm === e.pwm) else begin
      errors++;
      $error("FAIL %s pwm observed=%b expected=%b", e.tag, pwm, e.pwm);
    end
    checks++;
    assert (starved === e.starved) else begin
      errors++;
      $error("FAIL %s starved observed=%b expected=%b", e.tag, starved, e.starved);
    end
  endtask

  initial begin
    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, "reset0");
    cycle(1'b1, 1'b0, "reset1");
    drive(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, "prime_hold");

    // Enable gives the initial falling edge
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, "prime_fall");
    checks++;
    assert (dut.state === WAIT_LOAD) else begin
      errors++;
      $error("FAIL prime_state observed=%0d expected=%0d", dut.state, WAIT_LOAD);
    end
    cycle(1'b0, 1'b0, "wait_idle");

    // v=8: low 4, high 4; the load-cycle tick is not counted
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(8));
    cycle(1'b0, 1'b0, "v8_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 8; i++) cycle((i >= 4 && i < 8) ? 1'b1 : 1'b0, 1'b0, $sformatf("v8_t%0d", i));

    // v=7: low 4, high 3
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(7));
    cycle(1'b0, 1'b0, "v7_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 7; i++) cycle((i >= 4 && i < 7) ? 1'b1 : 1'b0, 1'b0, $sformatf("v7_t%0d", i));

    // v=0 and v=1: no high phase, back in WAIT_LOAD after one tick
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(0));
    cycle(1'b0, 1'b0, "v0_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, $sformatf("v0_t%0d", i));
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(1));
    cycle(1'b0, 1'b0, "v1_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, "v1_t1");
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(2));
    cycle(1'b0, 1'b0, "v2_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, "v2_t1");
    cycle(1'b0, 1'b0, "v2_t2");

    // v=100 with a 50-cycle enable freeze at tick 30 and ignored loads
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(100));
    cycle(1'b0, 1'b0, "v100_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 30; i++) cycle(1'b0, 1'b0, $sformatf("v100_t%0d", i));
    for (int j = 0; j < 50; j++) begin
      drive(1'b1, 1'b0, 1'b1, (j == 25), TW'(3));
      cycle(1'b0, 1'b0, $sformatf("v100_frz%0d", j));
    end
    for (int i = 31; i <= 100; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i == 60), TW'(5));
      cycle((i >= 50 && i < 100) ? 1'b1 : 1'b0, 1'b0, $sformatf("v100_t%0d", i));
    end

    // Starve watchdog: sets on the 255th idle cycle and is sticky across a load
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 255; i++) cycle(1'b0, (i == 254) ? 1'b1 : 1'b0, $sformatf("starve_%0d", i));
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(4));
    cycle(1'b0, 1'b1, "v4_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, "v4_t1");
    cycle(1'b1, 1'b1, "v4_t2");
    cycle(1'b1, 1'b1, "v4_t3");
    cycle(1'b0, 1'b1, "v4_t4");

    // Reset wins over load/tick/enable and clears starved
    drive(1'b0, 1'b1, 1'b1, 1'b1, TW'(6));
    cycle(1'b1, 1'b0, "rst_prio");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, "rst_prime_fall");

    // Reset mid-period discards the period; no fall until enable returns
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(10));
    cycle(1'b0, 1'b0, "v10_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 7; i++) cycle((i >= 5) ? 1'b1 : 1'b0, 1'b0, $sformatf("v10_t%0d", i));
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, "mid_rst");
    drive(1'b1, 1'b0, 1'b1, 1'b1, TW'(3));
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $sformatf("post_rst_hold%0d", i));
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, "post_rst_fall");
    drive(1'b1, 1'b1, 1'b1, 1'b1, TW'(2));
    cycle(1'b0, 1'b0, "post_v2_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, "post_v2_t1");
    cycle(1'b0, 1'b0, "post_v2_t2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
